instr_encoder_loader: RTL and testbench

INSTR_ENCODER_LOADER -- requirements
Module: instr_encoder_loader

---
 rtl/rv_pkg.sv | 16 +
 rtl/rv_instr_encode.sv | 32 +++
 rtl/instr_encoder_loader.sv | 65 ++++++
 tb/tb_instr_encoder_loader.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// rv_pkg: RV32I encoding constants, request class codes and loader FSM states,
// shared by the instruction loader and the core control unit.
package rv_pkg;
   localparam logic [2:0] CLS_LW = 3'd0, CLS_SW = 3'd1, CLS_R = 3'd2, CLS_I = 3'd3, CLS_BR = 3'd4;
   localparam logic [2:0] ALU_ADD = 3'b000, ALU_SUB = 3'b010, ALU_SLL = 3'b001, ALU_XOR = 3'b100;
   localparam logic [2:0] ALU_SRL = 3'b101, ALU_OR = 3'b110, ALU_AND = 3'b111, ALU_BAD = 3'b011;
   localparam logic [1:0] BR_EQ = 2'd0, BR_NE = 2'd1, BR_LT = 2'd2, BR_BAD = 2'd3;
   localparam logic [6:0] OPC_LOAD = 7'b0000011, OPC_STORE = 7'b0100011, OPC_OP = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM = 7'b0010011, OPC_BRANCH = 7'b1100011;
   localparam logic [2:0] F3_W = 3'b010, F3_BEQ = 3'b000, F3_BNE = 3'b001, F3_BLT = 3'b100;
   localparam logic [2:0] ST_IDLE = 3'd0, ST_ACCEPT = 3'd1, ST_WRITE = 3'd2, ST_DONE = 3'd3, ST_ERR = 3'd4;
   // add and sub share funct3 000; the remaining ALU codes are their own funct3
   function automatic logic [2:0] alu_funct3(input logic [2:0] a);
      return (a == ALU_SUB) ? ALU_ADD : a;
   endfunction
endpackage

// File: rtl/rv_instr_encode.sv
// rv_instr_encode: combinational RV32I encoder for loader requests, with illegal-request flag.
module rv_instr_encode
   import rv_pkg::*;
(
   input  logic [2:0]  op_class,
   input  logic [2:0]  alu_code,
   input  logic [1:0]  br_type,
   input  logic [4:0]  rd,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   input  logic [12:0] imm,
   output logic [31:0] word,
   output logic        illegal
);
   logic [2:0] f3_alu, f3_br;
   always_comb begin
      f3_alu = alu_funct3(alu_code);
      f3_br = (br_type == BR_LT) ? F3_BLT : (br_type == BR_NE) ? F3_BNE : F3_BEQ;
      case (op_class)
         CLS_LW:  word = {imm[11:0], rs1, F3_W, rd, OPC_LOAD};
         CLS_SW:  word = {imm[11:5], rs2, rs1, F3_W, imm[4:0], OPC_STORE};
         CLS_R:   word = {1'b0, alu_code == ALU_SUB, 5'b0, rs2, rs1, f3_alu, rd, OPC_OP};
         CLS_I:   word = {imm[11:0], rs1, f3_alu, rd, OPC_OPIMM};
         CLS_BR:  word = {imm[12], imm[10:5], rs2, rs1, f3_br, imm[4:1], imm[11], OPC_BRANCH};
         default: word = '0;
      endcase
      illegal = (op_class > CLS_BR)
         || ((op_class == CLS_R || op_class == CLS_I) && alu_code == ALU_BAD)
         || (op_class == CLS_I && alu_code == ALU_SUB)
         || (op_class == CLS_BR && (br_type == BR_BAD || imm[0]));
   end
endmodule

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: accepts encoded-instruction requests and writes them to
// instruction memory one word per two cycles, holding the core in reset meanwhile.
module instr_encoder_loader
   import rv_pkg::*;
#(
   parameter int ADDR_W = 6
)(
   input  logic              clk,
   input  logic              areset,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_last,
   input  logic [2:0]        op_class,
   input  logic [2:0]        alu_code,
   input  logic [1:0]        br_type,
   input  logic [4:0]        rd,
   input  logic [4:0]        rs1,
   input  logic [4:0]        rs2,
   input  logic [12:0]       imm,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_waddr,
   output logic [31:0]       imem_wdata,
   output logic              core_hold,
   output logic              done,
   output logic              error
);
   logic [2:0]        state;
   logic [ADDR_W-1:0] addr;
   logic [31:0]       enc_word;
   logic              enc_illegal, last_q;

   rv_instr_encode u_enc (
      .op_class(op_class), .alu_code(alu_code), .br_type(br_type),
      .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
      .word(enc_word), .illegal(enc_illegal)
   );

   // the address saturates at the top word; a non-final write there ends in ERR
   always_ff @(posedge clk or negedge areset)
      if (!areset) begin
         state <= ST_IDLE;
         addr <= '0;
         imem_wdata <= '0;
         last_q <= 1'b0;
      end else if (start) begin
         state <= ST_ACCEPT;
         addr <= '0;
      end else if (state == ST_ACCEPT && in_valid) begin
         state <= enc_illegal ? ST_ERR : ST_WRITE;
         imem_wdata <= enc_word;
         last_q <= in_last;
      end else if (state == ST_WRITE) begin
         state <= last_q ? ST_DONE : (&addr) ? ST_ERR : ST_ACCEPT;
         addr <= (&addr) ? addr : addr + 1'b1;
      end

   // a start arriving during WRITE drops that write
   assign in_ready = state == ST_ACCEPT;
   assign imem_we = state == ST_WRITE && !start;
   assign imem_waddr = addr;
   assign core_hold = state == ST_ACCEPT || state == ST_WRITE || state == ST_ERR;
   assign done = state == ST_DONE;
   assign error = state == ST_ERR;
endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb_instr_encoder_loader: directed sessions on a 64-word and a 4-word loader,
// checked every cycle against a transaction-level model plus literal words.
module tb_instr_encoder_loader;
   logic clk = 0, areset = 1, start_a = 0, start_b = 0, in_valid = 0, in_last = 0;
   logic [2:0] op_class = 0, alu_code = 0;
   logic [1:0] br_type = 0;
   logic [4:0] rd = 0, rs1 = 0, rs2 = 0;
   logic [12:0] imm = 0;
   logic rdy_a, we_a, hold_a, done_a, err_a, rdy_b, we_b, hold_b, done_b, err_b;
   logic [5:0] wa_a;
   logic [1:0] wa_b;
   logic [31:0] wd_a, wd_b;
   logic [31:0] qa0[$], qd0[$], qa1[$], qd1[$];
   int checks = 0, failures = 0;
   int phase[2], nxt[2], pa[2], depth[2];
   bit pend[2], plast[2];
   logic [31:0] pw[2];

   always #5 clk = ~clk;

   instr_encoder_loader #(.ADDR_W(6)) dut_a (
      .clk(clk), .areset(areset), .start(start_a), .in_valid(in_valid), .in_ready(rdy_a),
      .in_last(in_last), .op_class(op_class), .alu_code(alu_code), .br_type(br_type),
      .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm), .imem_we(we_a), .imem_waddr(wa_a),
      .imem_wdata(wd_a), .core_hold(hold_a), .done(done_a), .error(err_a));

   instr_encoder_loader #(.ADDR_W(2)) dut_b (
      .clk(clk), .areset(areset), .start(start_b), .in_valid(in_valid), .in_ready(rdy_b),
      .in_last(in_last), .op_class(op_class), .alu_code(alu_code), .br_type(br_type),
      .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm), .imem_we(we_b), .imem_waddr(wa_b),
      .imem_wdata(wd_b), .core_hold(hold_b), .done(done_b), .error(err_b));

   function automatic logic [31:0] ref_word(int unsigned op, int unsigned alu, int unsigned br,
         int unsigned d, int unsigned s1, int unsigned s2, int unsigned im);
      int unsigned lo, base;
      lo = im & 32'hFFF;
      base = (s1 << 15) | (d << 7);
      case (op)
         0: return (lo << 20) | base | (2 << 12) | 3;
         1: return ((lo >> 5) << 25) | (s2 << 20) | (s1 << 15) | (2 << 12) | ((lo & 31) << 7) | 35;
         2: return ((alu == 2) ? 32'h4000_0000 : 0) | (s2 << 20) | base | (((alu == 2) ? 0 : alu) << 12) | 51;
         3: return (lo << 20) | base | (alu << 12) | 19;
         default: return (((im >> 12) & 1) << 31) | (((im >> 5) & 63) << 25) | (s2 << 20) | (s1 << 15)
            | (((br == 2) ? 4 : br) << 12) | (((im >> 1) & 15) << 8) | (((im >> 11) & 1) << 7) | 99;
      endcase
   endfunction

   function automatic bit ref_illegal(int unsigned op, int unsigned alu, int unsigned br, int unsigned im);
      return op > 4 || ((op == 2 || op == 3) && alu == 3) || (op == 3 && alu == 2)
         || (op == 4 && (br == 3 || im % 2 == 1));
   endfunction

   // phase: 0 idle, 1 loading, 2 finished, 3 aborted; pend means a word is due out next cycle
   task automatic model_step(int k, bit st);
      if (st) begin
         phase[k] = 1; nxt[k] = 0; pend[k] = 0;
      end else if (pend[k]) begin
         pend[k] = 0;
         nxt[k]++;
         if (plast[k]) phase[k] = 2;
         else if (nxt[k] == depth[k]) phase[k] = 3;
      end else if (phase[k] == 1 && in_valid) begin
         if (ref_illegal(op_class, alu_code, br_type, imm)) phase[k] = 3;
         else begin
            pend[k] = 1; pa[k] = nxt[k]; plast[k] = in_last;
            pw[k] = ref_word(op_class, alu_code, br_type, rd, rs1, rs2, imm);
         end
      end
   endtask

   initial begin
      depth[0] = 64;
      depth[1] = 4;
   end

   always @(posedge clk or negedge areset)
      if (!areset) for (int k = 0; k < 2; k++) begin phase[k] = 0; pend[k] = 0; nxt[k] = 0; end
      else begin model_step(0, start_a); model_step(1, start_b); end

   task automatic cmp(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic cmp_dut(int k, logic r, logic w, logic h, logic d, logic e, logic [31:0] a, logic [31:0] wd);
      bit xw;
      xw = pend[k] && !(k == 0 ? start_a : start_b);
      cmp($sformatf("in_ready%0d", k), 32'(r), 32'(phase[k] == 1 && !pend[k]));
      cmp($sformatf("imem_we%0d", k), 32'(w), 32'(xw));
      cmp($sformatf("core_hold%0d", k), 32'(h), 32'(phase[k] == 1 || phase[k] == 3));
      cmp($sformatf("done%0d", k), 32'(d), 32'(phase[k] == 2));
      cmp($sformatf("error%0d", k), 32'(e), 32'(phase[k] == 3));
      if (xw) begin
         cmp($sformatf("imem_waddr%0d", k), a, 32'(pa[k]));
         cmp($sformatf("imem_wdata%0d", k), wd, pw[k]);
      end
   endtask

   always @(negedge clk) if (areset) begin
      cmp_dut(0, rdy_a, we_a, hold_a, done_a, err_a, 32'(wa_a), wd_a);
      cmp_dut(1, rdy_b, we_b, hold_b, done_b, err_b, 32'(wa_b), wd_b);
   end

   always @(negedge clk) begin
      if (we_a) begin qa0.push_back(32'(wa_a)); qd0.push_back(wd_a); end
      if (we_b) begin qa1.push_back(32'(wa_b)); qd1.push_back(wd_b); end
   end

   task automatic tick(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse(int k);
      qa0.delete(); qd0.delete(); qa1.delete(); qd1.delete();
      if (k == 0) start_a = 1; else start_b = 1;
      tick(1);
      start_a = 0; start_b = 0;
   endtask

   task automatic send(int k, int op, int alu, int br, int d, int s1, int s2, int im, bit last);
      int n = 0;
      op_class = 3'(op); alu_code = 3'(alu); br_type = 2'(br);
      rd = 5'(d); rs1 = 5'(s1); rs2 = 5'(s2); imm = 13'(im); in_last = last; in_valid = 1;
      @(negedge clk);
      while (!(k == 0 ? rdy_a : rdy_b) && n < 20) begin n++; @(negedge clk); end
      if (n == 20) begin
         checks++; failures++;
         $display("FAIL handshake%0d actual=no_ready required=ready", k);
      end
      @(posedge clk); #1;
      in_valid = 0; in_last = 0;
   endtask

   task automatic status(string nm, int k, logic xd, logic xe, logic xh, logic xr);
      cmp({nm, "_done"}, 32'(k == 0 ? done_a : done_b), 32'(xd));
      cmp({nm, "_error"}, 32'(k == 0 ? err_a : err_b), 32'(xe));
      cmp({nm, "_hold"}, 32'(k == 0 ? hold_a : hold_b), 32'(xh));
      cmp({nm, "_ready"}, 32'(k == 0 ? rdy_a : rdy_b), 32'(xr));
   endtask

   task automatic zero_check(string nm);
      status(nm, 0, 0, 0, 0, 0);
      cmp({nm, "_we"}, 32'(we_a), 0);
      cmp({nm, "_waddr"}, 32'(wa_a), 0);
      cmp({nm, "_wdata"}, wd_a, 0);
   endtask

   int tbl[8][9] = '{
      '{4, 7, 1, 9, 3, 4, 'h1FFC, 0, 0}, '{4, 0, 2, 0, 2, 7, 'h0802, 0, 0},
      '{2, 1, 3, 31, 30, 29, 'h1FFF, 0, 0}, '{2, 7, 0, 4, 5, 6, 0, 0, 0},
      '{3, 5, 0, 8, 9, 0, 'h07FF, 0, 0}, '{3, 6, 0, 10, 11, 0, 'h1800, 0, 0},
      '{0, 3, 3, 12, 13, 31, 'h0FFF, 0, 0}, '{1, 0, 0, 0, 14, 15, 'h1FE1, 1, 0}};

   initial begin
      #2 areset = 0;
      #2 zero_check("reset");
      cmp("reset_b_we", 32'(we_b), 0);
      #18 areset = 1;
      tick(1);
      pulse(0);
      send(0, 2, 0, 0, 3, 1, 2, 0, 1);
      tick(2);
      cmp("add_count", qa0.size(), 1);
      cmp("add_addr", qa0[0], 0);
      cmp("add_word", qd0[0], 32'h002081B3);
      status("add", 0, 1, 0, 0, 0);
      pulse(0);
      send(0, 2, 2, 0, 3, 1, 2, 0, 1);
      tick(2);
      cmp("sub_word", qd0[0], 32'h402081B3);
      status("sub", 0, 1, 0, 0, 0);
      pulse(0);
      send(0, 0, 0, 0, 5, 1, 0, 8, 0);
      send(0, 1, 0, 0, 0, 1, 5, 12, 0);
      send(0, 4, 0, 0, 0, 1, 2, 8, 0);
      send(0, 3, 4, 0, 7, 5, 0, 'h1FFF, 1);
      tick(2);
      cmp("seq_count", qa0.size(), 4);
      for (int i = 0; i < 4; i++) cmp($sformatf("seq_addr%0d", i), qa0[i], 32'(i));
      cmp("seq_lw", qd0[0], 32'h0080A283);
      cmp("seq_sw", qd0[1], 32'h0050A623);
      cmp("seq_beq", qd0[2], 32'h00208463);
      cmp("seq_xori", qd0[3], 32'hFFF2C393);
      status("seq", 0, 1, 0, 0, 0);
      pulse(0);
      send(0, 3, 2, 0, 1, 1, 0, 4, 1);
      tick(2);
      cmp("isub_writes", qa0.size(), 0);
      status("isub", 0, 0, 1, 1, 0);
      pulse(0);
      send(0, 4, 0, 0, 0, 1, 2, 7, 1);
      tick(2);
      cmp("bodd_writes", qa0.size(), 0);
      status("bodd", 0, 0, 1, 1, 0);
      pulse(0); send(0, 6, 0, 0, 1, 1, 1, 0, 1); tick(2); status("op6", 0, 0, 1, 1, 0);
      pulse(0); send(0, 2, 3, 0, 1, 1, 1, 0, 1); tick(2); status("alu3", 0, 0, 1, 1, 0);
      pulse(0); send(0, 4, 0, 3, 0, 1, 1, 4, 1); tick(2); status("br3", 0, 0, 1, 1, 0);
      cmp("illegal_writes", qa0.size(), 0);
      pulse(0);
      for (int i = 0; i < 8; i++)
         send(0, tbl[i][0], tbl[i][1], tbl[i][2], tbl[i][3], tbl[i][4], tbl[i][5], tbl[i][6], tbl[i][7] != 0);
      tick(2);
      cmp("mix_count", qa0.size(), 8);
      cmp("mix_bne", qd0[0], 32'hFE419EE3);
      cmp("mix_last_addr", qa0[7], 7);
      status("mix", 0, 1, 0, 0, 0);
      pulse(0);
      send(0, 0, 0, 0, 5, 1, 0, 8, 0);
      send(0, 1, 0, 0, 0, 1, 5, 12, 0);
      start_a = 1;
      tick(1);
      start_a = 0;
      send(0, 2, 0, 0, 3, 1, 2, 0, 1);
      tick(2);
      cmp("restart_count", qa0.size(), 2);
      cmp("restart_addr", qa0[1], 0);
      cmp("restart_word", qd0[1], 32'h002081B3);
      pulse(1);
      for (int i = 0; i < 4; i++) send(1, 2, 0, 0, i + 1, 1, 2, 0, 0);
      tick(2);
      cmp("ovf_count", qa1.size(), 4);
      for (int i = 0; i < 4; i++) cmp($sformatf("ovf_addr%0d", i), qa1[i], 32'(i));
      status("ovf", 1, 0, 1, 1, 0);
      pulse(1);
      for (int i = 0; i < 4; i++) send(1, 3, 0, 0, i + 1, 1, 0, i, i == 3);
      tick(2);
      cmp("full_count", qa1.size(), 4);
      status("full", 1, 1, 0, 0, 0);
      pulse(0);
      send(0, 2, 0, 0, 3, 1, 2, 0, 0);
      cmp("pre_reset_we", 32'(we_a), 1);
      areset = 0;
      #1 zero_check("midreset");
      qa0.delete(); qd0.delete();
      @(negedge clk); #2 areset = 1;
      tick(1);
      cmp("post_reset_writes", qa0.size(), 0);
      pulse(0);
      send(0, 2, 2, 0, 3, 1, 2, 0, 1);
      tick(2);
      cmp("reload_count", qa0.size(), 1);
      cmp("reload_addr", qa0[0], 0);
      cmp("reload_word", qd0[0], 32'h402081B3);
      status("reload", 0, 1, 0, 0, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
